imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Controller that owns the instruction-memory address/write port and sequences fetch for the 8-bit single-cycle core.
- Loads a program into instruction memory from a byte-stream loader.
- Then runs, halts or single-steps the core.
- Maintains the PC and resolves jumps (opcode 2'b11) itself.
- Sits between the external loader/debug host, the instruction memory and the core's decode stage.

Parameters:
ADDR_W, 8, width of PC and memory address.
DATA_W, 8, instruction width.
MEM_DEPTH, 16, number of valid instruction words; legal addresses 0..MEM_DEPTH-1.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
Reset  in  1  reset, synchronous, active-low
ld_start  in  1  request to enter LOAD (pulse)
ld_valid  in  1  loader byte valid
ld_data  in  DATA_W  loader byte
ld_last  in  1  marks final byte of program
ld_ready  out  1  controller accepts loader byte
ld_count  out  ADDR_W  bytes written by last/current load
run_req  in  1  start/resume free-running execution
halt_req  in  1  stop execution
step_req  in  1  execute exactly one instruction from HALT
mem_addr  out  ADDR_W  instruction memory address
mem_wdata  out  DATA_W  instruction memory write data
mem_we  out  1  instruction memory write enable
mem_rdata  in  DATA_W  instruction memory read data (combinational read)
pc  out  ADDR_W  current PC
instr  out  DATA_W  instruction issued to core (= mem_rdata)
instr_valid  out  1  core must execute instr this cycle
state  out  3  current FSM state
fault  out  1  jump target out of range
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (Reset==0 at a clk edge):
  - state=IDLE; pc=0, ld_addr=0, ld_count=0, fault=0, instr_count=0.
  - Outputs ld_ready=0, mem_we=0, instr_valid=0.
  - Overrides every other input, including mid-load or mid-run.
  - Memory contents are not touched.
- States: IDLE, LOAD, RUN, HALT, STEP.
- Command priority in IDLE and HALT: ld_start > run_req > step_req. step_req is ignored in IDLE.
- Address mux: mem_addr=ld_addr in LOAD, else pc. mem_wdata=ld_data always.
- IDLE:
  - ld_start -> LOAD; clears ld_addr, ld_count, instr_count, fault.
  - run_req -> RUN with pc=0.
- LOAD:
  - ld_ready=1; mem_we = ld_valid (combinational).
  - Each accepted byte is written at ld_addr, then ld_addr++ and ld_count++.
  - Exit to IDLE after the byte with ld_last=1, or after the byte written at MEM_DEPTH-1 (further bytes are not accepted).
  - Ignores run/halt/step.
- RUN:
  - instr_valid=1 every cycle; instruction at pc issues; instr_count++ (saturates at all-ones).
  - Next PC:
    - if instr[7:6]==2'b11, next PC = zero-extended instr[5:0];
    - else pc+1, wrapping from MEM_DEPTH-1 to 0.
  - Jump target >= MEM_DEPTH: the instruction issues, pc holds at the jump's address, fault=1, state -> HALT.
  - halt_req: the current instruction still issues and pc advances, then -> HALT.
  - ld_start is ignored in RUN.
- HALT:
  - instr_valid=0; pc holds.
  - ld_start -> LOAD.
  - run_req -> RUN and clears fault.
  - step_req -> STEP.
- STEP:
  - Exactly one cycle with instr_valid=1; same next-PC and fault rules as RUN; always returns to HALT.
  - halt_req is irrelevant here.
- Latency: PC update is visible the cycle after issue; instr is available the same cycle as pc (combinational memory).
- Simultaneous events:
  - ld_valid with ld_last at address MEM_DEPTH-1: a single write, then IDLE.
  - run_req and halt_req together in HALT: RUN wins. In RUN, halt wins.

Decomposition:
- Shared package holds:
  - opcode constants OP_MOV=2'b00, OP_SLL=2'b01, OP_J=2'b11;
  - field slices (opcode [7:6], jump target [5:0]);
  - state encoding IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4.
- One natural sub-module: imem_pc_next (combinational). It takes pc and instr and returns next_pc and oob.

Test Plan:
- Load: ld_start, then bytes 33,71,1e,c2,5b,1b, with ld_last on the 6th -> writes at mem addr 0..5, ld_count=6, state IDLE, ld_ready drops.
- Run that program: run_req -> pc sequence 0,1,2,3,2,3,2… (c2 jumps to 2); instr_count increments once per cycle.
- Halt/step: halt_req while pc=3 issuing -> HALT with pc=2, instr_valid=0. Then step_req -> one issue at pc=2, back in HALT at pc=3.
- Fault: program with byte FF at addr 0, run -> one issue, fault=1, HALT, pc=0. Then run_req clears fault.
- Wrap/overflow: load 20 bytes without ld_last -> only 16 written, ld_count=16. Non-jump at pc=15 -> next pc=0.
- Reset mid-load after 3 bytes -> IDLE, ld_count=0, mem_we=0 next cycle. Reset during RUN -> pc=0, instr_valid=0.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: opcodes,
// instruction field slices and FSM state encoding.
package imem_fetch_ctrl_pkg;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int TGT_HI = 5;
    localparam int TGT_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_STEP = 3'd4
    } state_e;

    function automatic logic [1:0] opcode_of(input logic [7:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [5:0] jump_target_of(input logic [7:0] instr);
        return instr[TGT_HI:TGT_LO];
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction memory port: the controller drives address/write data/enable,
// the memory returns combinational read data.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/imem_pc_next.sv
// Next-PC resolution: absolute jumps on OP_J, otherwise sequential with
// wrap at the top of the populated memory; flags out-of-range jump targets.
module imem_pc_next
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              oob
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    logic              is_jump_s;
    logic [5:0]        target_s;

    // Select jump target or sequential successor and range-check the target
    always_comb begin
        is_jump_s = (opcode_of(instr) == OP_J);
        target_s  = jump_target_of(instr);
        next_pc   = {ADDR_W{1'b0}};
        oob       = 1'b0;
        if (is_jump_s) begin
            next_pc = ADDR_W'(target_s);
            oob     = (32'(target_s) >= MEM_DEPTH);
        end else if (pc == LAST_ADDR) begin
            next_pc = {ADDR_W{1'b0}};
        end else begin
            next_pc = pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: loads program bytes into instruction memory,
// then runs, halts or single-steps the core while tracking PC and faults.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ld_count,
    input  logic              run_req,
    input  logic              halt_req,
    input  logic              step_req,
    imem_fetch_ctrl_if.master mem,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [2:0]        state,
    output logic              fault,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] ld_addr_r;
    logic [ADDR_W-1:0] ld_count_r;
    logic              fault_r;
    logic              ld_ready_r;
    logic              instr_valid_r;
    logic [CNT_W-1:0]  instr_count_r;

    logic [ADDR_W-1:0] next_pc_s;
    logic              oob_s;
    logic              last_byte_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    imem_pc_next #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_next (
        .pc      (pc_r),
        .instr   (mem.mem_rdata),
        .next_pc (next_pc_s),
        .oob     (oob_s)
    );

    // Memory port mux; writes are gated by Reset so a reset cycle never disturbs memory
    always_comb begin
        mem.mem_wdata = ld_data;
        mem.mem_we    = ld_ready_r & ld_valid & Reset;
        last_byte_s   = ld_last | (ld_addr_r == LAST_ADDR);
        if (state_r == ST_LOAD) begin
            mem.mem_addr = ld_addr_r;
        end else begin
            mem.mem_addr = pc_r;
        end
    end

    // Control FSM with registered handshake and issue outputs
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= {ADDR_W{1'b0}};
            ld_addr_r     <= {ADDR_W{1'b0}};
            ld_count_r    <= {ADDR_W{1'b0}};
            fault_r       <= 1'b0;
            ld_ready_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ld_start) begin
                        state_r       <= ST_LOAD;
                        ld_ready_r    <= 1'b1;
                        ld_addr_r     <= {ADDR_W{1'b0}};
                        ld_count_r    <= {ADDR_W{1'b0}};
                        instr_count_r <= {CNT_W{1'b0}};
                        fault_r       <= 1'b0;
                    end else if (run_req) begin
                        state_r       <= ST_RUN;
                        pc_r          <= {ADDR_W{1'b0}};
                        instr_valid_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        ld_addr_r  <= ld_addr_r + ADDR_W'(1);
                        ld_count_r <= ld_count_r + ADDR_W'(1);
                        if (last_byte_s) begin
                            state_r    <= ST_IDLE;
                            ld_ready_r <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    instr_count_r <= sat_inc(instr_count_r);
                    if (oob_s) begin
                        fault_r       <= 1'b1;
                        state_r       <= ST_HALT;
                        instr_valid_r <= 1'b0;
                    end else begin
                        pc_r <= next_pc_s;
                        if (halt_req) begin
                            state_r       <= ST_HALT;
                            instr_valid_r <= 1'b0;
                        end
                    end
                end
                ST_HALT: begin
                    // A new load from HALT starts from a clean slate, same as from IDLE
                    if (ld_start) begin
                        state_r       <= ST_LOAD;
                        ld_ready_r    <= 1'b1;
                        ld_addr_r     <= {ADDR_W{1'b0}};
                        ld_count_r    <= {ADDR_W{1'b0}};
                        instr_count_r <= {CNT_W{1'b0}};
                        fault_r       <= 1'b0;
                    end else if (run_req) begin
                        state_r       <= ST_RUN;
                        fault_r       <= 1'b0;
                        instr_valid_r <= 1'b1;
                    end else if (step_req) begin
                        state_r       <= ST_STEP;
                        instr_valid_r <= 1'b1;
                    end
                end
                ST_STEP: begin
                    instr_count_r <= sat_inc(instr_count_r);
                    state_r       <= ST_HALT;
                    instr_valid_r <= 1'b0;
                    if (oob_s) begin
                        fault_r <= 1'b1;
                    end else begin
                        pc_r <= next_pc_s;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    ld_ready_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = ld_ready_r;
    assign ld_count    = ld_count_r;
    assign pc          = pc_r;
    assign instr       = mem.mem_rdata;
    assign instr_valid = instr_valid_r;
    assign state       = state_r;
    assign fault       = fault_r;
    assign instr_count = instr_count_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: load, run, halt/step, fault, wrap and reset cases.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic        ld_start, ld_valid, ld_last;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [7:0]  ld_count;
    logic        run_req, halt_req, step_req;
    logic [7:0]  pc, instr;
    logic        instr_valid;
    logic [2:0]  state;
    logic        fault;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] imem [0:15];
    logic [7:0] prog [0:5];
    logic [7:0] run_pc [0:7];

    imem_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(8)) mem_bus ();

    imem_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(8), .MEM_DEPTH(16), .CNT_W(16)
    ) dut (
        .clk(clk), .Reset(Reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_count(ld_count),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .mem(mem_bus.master),
        .pc(pc), .instr(instr), .instr_valid(instr_valid), .state(state),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Behavioural instruction memory: combinational read, clocked write
    assign mem_bus.mem_rdata = (mem_bus.mem_addr < 8'd16) ? imem[mem_bus.mem_addr[3:0]] : 8'h00;
    always @(posedge clk) begin
        if (mem_bus.mem_we && (mem_bus.mem_addr < 8'd16)) imem[mem_bus.mem_addr[3:0]] <= mem_bus.mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prog[0] = 8'h33; prog[1] = 8'h71; prog[2] = 8'h1e;
        prog[3] = 8'hc2; prog[4] = 8'h5b; prog[5] = 8'h1b;
        run_pc[0] = 8'd0; run_pc[1] = 8'd1; run_pc[2] = 8'd2; run_pc[3] = 8'd3;
        run_pc[4] = 8'd2; run_pc[5] = 8'd3; run_pc[6] = 8'd2; run_pc[7] = 8'd3;

        Reset = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        tick(); tick();
        chk("rst_state", state, 3'd0);
        chk("rst_pc", pc, 8'd0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_iv", instr_valid, 1'b0);
        chk("rst_ld_count", ld_count, 8'd0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_icount", instr_count, 16'd0);
        chk("rst_we", mem_bus.mem_we, 1'b0);
        Reset = 1'b1;

        // Load six-byte program
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        chk("load_state", state, 3'd1);
        chk("load_ready", ld_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 5);
            #1;
            chk("load_we", mem_bus.mem_we, 1'b1);
            chk("load_addr", mem_bus.mem_addr, 32'(i));
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("load_done_state", state, 3'd0);
        chk("load_count", ld_count, 8'd6);
        chk("load_ready_drop", ld_ready, 1'b0);
        chk("load_mem0", imem[0], 8'h33);
        chk("load_mem5", imem[5], 8'h1b);

        // Run: 0,1,2,3,2,3,2,3 with c2 jumping back to 2
        run_req = 1'b1; tick(); run_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("run_pc", pc, run_pc[k]);
            chk("run_instr", instr, prog[run_pc[k]]);
            chk("run_icount", instr_count, 32'(k));
            chk("run_iv", instr_valid, 1'b1);
            tick();
        end
        chk("run_pc_pre_halt", pc, 8'd3);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_state", state, 3'd3);
        chk("halt_pc", pc, 8'd2);
        chk("halt_iv", instr_valid, 1'b0);
        chk("halt_icount", instr_count, 16'd8);

        // Single step from HALT
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("step_state", state, 3'd4);
        chk("step_iv", instr_valid, 1'b1);
        chk("step_pc", pc, 8'd2);
        chk("step_instr", instr, 8'h1e);
        tick();
        chk("step_back_state", state, 3'd3);
        chk("step_back_pc", pc, 8'd3);
        chk("step_back_iv", instr_valid, 1'b0);
        chk("step_icount", instr_count, 16'd9);

        // Out-of-range jump fault
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        chk("fload_state", state, 3'd1);
        chk("fload_icount_clr", instr_count, 16'd0);
        ld_valid = 1'b1; ld_data = 8'hff; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("fload_count", ld_count, 8'd1);
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("fault_run_instr", instr, 8'hff);
        tick();
        chk("fault_set", fault, 1'b1);
        chk("fault_state", state, 3'd3);
        chk("fault_pc", pc, 8'd0);
        chk("fault_icount", instr_count, 16'd1);
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("fault_clr", fault, 1'b0);
        chk("fault_clr_state", state, 3'd2);
        tick();
        chk("fault_again", fault, 1'b1);

        // Overflow load: 20 bytes, only 16 accepted
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ld_valid = 1'b1; ld_data = 8'h20 + 8'(i);
            #1;
            chk("ovf_we", mem_bus.mem_we, (i < 16) ? 1'b1 : 1'b0);
            tick();
        end
        ld_valid = 1'b0;
        chk("ovf_state", state, 3'd0);
        chk("ovf_count", ld_count, 8'd16);
        chk("ovf_mem0", imem[0], 8'h20);
        chk("ovf_mem15", imem[15], 8'h2f);

        // Sequential wrap from pc=15 to 0
        run_req = 1'b1; tick(); run_req = 1'b0;
        chk("wrap_pc0", pc, 8'd0);
        for (int k = 0; k < 15; k++) tick();
        chk("wrap_pc15", pc, 8'd15);
        chk("wrap_instr15", instr, 8'h2f);
        tick();
        chk("wrap_pc_back", pc, 8'd0);
        chk("wrap_icount", instr_count, 16'd16);
        chk("wrap_state", state, 3'd2);

        // Reset during RUN
        Reset = 1'b0; tick(); Reset = 1'b1;
        chk("rrun_pc", pc, 8'd0);
        chk("rrun_iv", instr_valid, 1'b0);
        chk("rrun_state", state, 3'd0);
        chk("rrun_icount", instr_count, 16'd0);

        // Reset in the middle of a load
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 8'ha0 + 8'(i); tick();
        end
        ld_data = 8'haa; Reset = 1'b0;
        #1;
        chk("rload_we_in_rst", mem_bus.mem_we, 1'b0);
        tick();
        Reset = 1'b1;
        #1;
        chk("rload_state", state, 3'd0);
        chk("rload_count", ld_count, 8'd0);
        chk("rload_we", mem_bus.mem_we, 1'b0);
        chk("rload_ready", ld_ready, 1'b0);
        chk("rload_mem2", imem[2], 8'ha2);
        chk("rload_mem3", imem[3], 8'h23);
        ld_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
